// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM responder and its storage array.
package ram_pkg;

  localparam int LATENCY_DEF = 2;
  localparam int DEPTH_DEF   = 128;
  localparam int ADDR_W      = 9;
  localparam int WIDX_W      = ADDR_W - 2;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = DATA_W / 8;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_array.sv
// DEPTH x 32 storage: synchronous byte-enabled write, registered synchronous read.
module ram_array
  import ram_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are never cleared; only the read register follows reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Request/response RAM front end: accepts one access in IDLE, waits LATENCY
// cycles, completes it on the edge into DONE and pulses ready.
module ram_responder
  import ram_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [8:0]  ramaddr,
  input  logic [31:0] ramstore,
  input  logic [3:0]  ramstrobe,
  output logic [31:0] ramload,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  localparam int AW = idx_width(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDX_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic              wr_q, wr_d;
  logic              rej_q, rej_d;

  logic              live_rej;
  logic              go_done;
  logic [WIDX_W-1:0] acc_idx;
  logic [DATA_W-1:0] acc_data;
  logic [STRB_W-1:0] acc_strb;
  logic              acc_wr;
  logic              acc_rej;
  logic              mem_we;
  logic              mem_re;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    strb_d   = strb_q;
    wr_d     = wr_q;
    rej_d    = rej_q;
    go_done  = 1'b0;

    live_rej = (Ren && Wen) || (ramaddr[1:0] != 2'b00)
               || (32'(ramaddr[ADDR_W-1:2]) >= 32'(DEPTH));

    unique case (state_q)
      IDLE: begin
        if (Ren || Wen) begin
          idx_d  = ramaddr[ADDR_W-1:2];
          data_d = ramstore;
          strb_d = ramstrobe;
          wr_d   = Wen;
          rej_d  = live_rej;
          if (LATENCY == 0) begin
            state_d = DONE;
            go_done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          go_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // With zero latency the access happens on the accepting edge, so the
    // array must see the live request rather than the not-yet-latched copy.
    if (state_q == IDLE) begin
      acc_idx  = ramaddr[ADDR_W-1:2];
      acc_data = ramstore;
      acc_strb = ramstrobe;
      acc_wr   = Wen;
      acc_rej  = live_rej;
    end else begin
      acc_idx  = idx_q;
      acc_data = data_q;
      acc_strb = strb_q;
      acc_wr   = wr_q;
      acc_rej  = rej_q;
    end

    mem_we = go_done && acc_wr && !acc_rej && nRST;
    mem_re = go_done && !acc_wr && !acc_rej && nRST;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rej_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rej_q   <= rej_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    data_q <= data_d;
    strb_q <= strb_d;
  end

  ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .nrst  (nRST),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (acc_idx[AW-1:0]),
    .wdata (acc_data),
    .wstrb (acc_strb),
    .rdata (ramload)
  );

  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);
  assign error = ready && rej_q;

endmodule
